// File: rtl/lifo_reverser_pkg.sv
// Shared types and defaults for the LIFO-based frame reverser and its LIFO partner.
// Holds the FSM state encoding, default widths and the counter-width helper.
package lifo_reverser_pkg;

  localparam int DEF_DATA_W    = 10;
  localparam int DEF_LIFO_SIZE = 6;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // A counter that must reach the full depth needs one state more than the depth.
  function automatic int cnt_width(input int size);
    return $clog2(size + 1);
  endfunction

endpackage

// File: rtl/lifo_reverser_if.sv
// Bundles the upstream stream, downstream stream, LIFO port and status flags
// of the reverser so the block and its environment share one connection.
interface lifo_reverser_if #(
  parameter int DATA_W = lifo_reverser_pkg::DEF_DATA_W
);

  // Handshake: a word moves on a rising clock edge exactly when valid & ready
  // are both high; once valid rises, data/last stay stable until that edge.
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              in_ready;

  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_ready;

  logic              lifo_write;
  logic              lifo_read;
  logic [DATA_W-1:0] lifo_datain;
  logic [DATA_W-1:0] lifo_dataout;
  logic              lifo_val;
  logic              lifo_full;

  logic              ovf;
  logic              err;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    input  lifo_dataout, lifo_val, lifo_full,
    output in_ready, out_valid, out_data, out_last,
    output lifo_write, lifo_read, lifo_datain,
    output ovf, err
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    output lifo_dataout, lifo_val, lifo_full,
    input  in_ready, out_valid, out_data, out_last,
    input  lifo_write, lifo_read, lifo_datain,
    input  ovf, err
  );

endinterface

// File: rtl/lifo.sv
// Simple stack used as the partner storage of the reverser: a push stores on
// the clock edge, a pop returns its word in dataout with val high one cycle later.
module lifo
  import lifo_reverser_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int LIFO_SIZE = DEF_LIFO_SIZE
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              write,
  input  logic              read,
  input  logic [DATA_W-1:0] datain,
  output logic [DATA_W-1:0] dataout,
  output logic              val,
  output logic              full,
  output logic              empty
);

  localparam int CNT_W = cnt_width(LIFO_SIZE);
  localparam int IDX_W = (LIFO_SIZE > 1) ? $clog2(LIFO_SIZE) : 1;
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(LIFO_SIZE);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic [DATA_W-1:0] mem [LIFO_SIZE];
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  below;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == DEPTH);
  assign empty   = (count == '0);
  assign below   = count - ONE;
  // A simultaneous push and pop is treated as a push only.
  assign do_push = write & ~full;
  assign do_pop  = read & ~empty & ~write;

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[count[IDX_W-1:0]] <= datain;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count   <= '0;
      dataout <= '0;
      val     <= 1'b0;
    end else begin
      val <= do_pop;
      if (do_push) begin
        count <= count + ONE;
      end else if (do_pop) begin
        count   <= below;
        dataout <= mem[below[IDX_W-1:0]];
      end
    end
  end

endmodule

// File: rtl/lifo_reverser.sv
// Frame reverser: fills an external LIFO with one upstream frame, then drains it
// word by word so the frame leaves in reverse order, the first-written word last.
module lifo_reverser
  import lifo_reverser_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int LIFO_SIZE = DEF_LIFO_SIZE
) (
  input  logic                               clock,
  input  logic                               reset,
  lifo_reverser_if.slave                     bus,
  output state_t                             state_dbg,
  output logic [cnt_width(LIFO_SIZE)-1:0]    cnt_dbg
);

  localparam int CNT_W = cnt_width(LIFO_SIZE);
  localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(LIFO_SIZE);
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(LIFO_SIZE - 1);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              run;
  logic              pending;
  logic              pop_last;
  logic              out_valid_q;
  logic              out_last_q;
  logic [DATA_W-1:0] out_data_q;
  logic              err_q;

  logic              in_ready_c;
  logic              write_c;
  logic              read_c;
  logic              ovf_c;
  logic              out_acc;
  logic              bad_val;

  assign out_acc = out_valid_q & bus.out_ready;
  // Either an unsolicited LIFO word or a missing one after a pop.
  assign bad_val = (bus.lifo_val & ~pending) | (pending & ~bus.lifo_val);

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    in_ready_c = 1'b0;
    write_c    = 1'b0;
    read_c     = 1'b0;
    ovf_c      = 1'b0;
    case (state)
      FILL: begin
        // run keeps the upstream port closed while reset is held.
        in_ready_c = run & (cnt < MAX_CNT) & ~bus.lifo_full;
        if (bus.in_valid && in_ready_c) begin
          write_c = 1'b1;
          cnt_nxt = cnt + ONE;
          if (bus.in_last) begin
            state_nxt = DRAIN;
          end else if (cnt == LAST_SLOT) begin
            state_nxt = DRAIN;
            ovf_c     = 1'b1;
          end
        end
      end
      DRAIN: begin
        if ((cnt != '0) && !pending && !out_valid_q) begin
          read_c  = 1'b1;
          cnt_nxt = cnt - ONE;
        end
        if (out_acc && out_last_q) begin
          state_nxt = FILL;
        end
      end
      default: begin
        state_nxt = FILL;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= FILL;
      cnt      <= '0;
      run      <= 1'b0;
      pending  <= 1'b0;
      pop_last <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      run   <= 1'b1;
      if (read_c) begin
        pending  <= 1'b1;
        pop_last <= (cnt == ONE);
      end else begin
        pending <= 1'b0;
      end
      if (bad_val) begin
        err_q <= 1'b1;
      end
    end
  end

  // Output register: loaded from the LIFO the cycle after a pop, held until taken.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else if (pending && bus.lifo_val) begin
      out_valid_q <= 1'b1;
      out_last_q  <= pop_last;
      out_data_q  <= bus.lifo_dataout;
    end else if (out_acc) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end
  end

  assign bus.in_ready    = in_ready_c;
  assign bus.lifo_write  = write_c;
  assign bus.lifo_read   = read_c;
  assign bus.lifo_datain = write_c ? bus.in_data : '0;
  assign bus.ovf         = ovf_c;
  assign bus.err         = err_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_last    = out_last_q;

  assign state_dbg = state;
  assign cnt_dbg   = cnt;

endmodule
